// File: rtl/bias_pkg.sv
// bias_pkg: shared types and arithmetic helpers for the bias add stage.
//   bias_sm_t  : 16-bit sign-magnitude bias word.
//   sm_to_tc   : sign-magnitude -> two's complement; negative zero maps to 0.
//   sat_trunc  : treats value as an in_w-bit signed number and clips it to
//                the signed out_w range.
// Both helpers work on 64-bit containers, so ACC_W+1 must not exceed 64.
package bias_pkg;

  localparam int BIAS_W_DEF = 16;

  typedef logic [BIAS_W_DEF-1:0] bias_sm_t;

  function automatic logic signed [63:0] sm_to_tc(input logic [63:0] sm, input int width);
    logic [63:0] mag;
    logic [63:0] sgn;
    mag = sm & ((64'd1 << (width - 1)) - 64'd1);
    sgn = (sm >> (width - 1)) & 64'd1;
    // -0 falls out naturally as 0
    if (sgn != 64'd0) return -$signed(mag);
    else return $signed(mag);
  endfunction

  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] value,
                                                   input int in_w, input int out_w);
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v  = (value <<< (64 - in_w)) >>> (64 - in_w);
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/bias_regfile.sv
// bias_regfile: NUM_CH x BIAS_W bias table.
//   clk, rst       : clock, synchronous active-high reset (clears all entries)
//   wr_en/addr/data: synchronous write port, visible the cycle after the write
//   rd_addr/rd_data: asynchronous read port; a same-cycle write is not yet
//                    visible, so a colliding read returns the old entry
module bias_regfile #(
  parameter int NUM_CH = 32,
  parameter int BIAS_W = 16,
  parameter int AW     = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [BIAS_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [BIAS_W-1:0] rd_data
);

  localparam logic [AW:0] DEPTH = (AW+1)'(NUM_CH);

  logic [NUM_CH-1:0][BIAS_W-1:0] mem;

  always_ff @(posedge clk) begin
    if (rst) mem <= '0;
    else if (wr_en && ({1'b0, wr_addr} < DEPTH)) mem[wr_addr] <= wr_data;
  end

  // out-of-range indices (non power-of-two NUM_CH) read as zero bias
  assign rd_data = ({1'b0, rd_addr} < DEPTH) ? mem[rd_addr] : '0;

endmodule

// File: rtl/bias_add_stage.sv
// bias_add_stage: per-channel bias add, arithmetic shift and saturation in a
// two-stage valid/ready pipeline.
//   clk, rst                  : clock, synchronous active-high reset
//   bias_wr_en/addr/data      : run-time write of a sign-magnitude bias entry
//   in_valid/in_ready/in_data : accumulator stream, one channel per beat
//   in_last                   : last channel of a pixel
//   out_valid/out_ready       : result handshake
//   out_data/out_ch/out_last  : saturated result, its channel, delayed in_last
//   sat_flag                  : out_data was clipped
//   frame_err                 : sticky; in_last disagreed with channel counter
// Build option: define BIAS_ADD_RELU_EN to clamp negative results to 0 after
// saturation (does not affect sat_flag or latency).
module bias_add_stage
  import bias_pkg::*;
#(
  parameter int NUM_CH = 32,
  parameter int ACC_W  = 32,
  parameter int BIAS_W = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bias_wr_en,
  input  logic [$clog2(NUM_CH)-1:0] bias_wr_addr,
  input  logic [BIAS_W-1:0]         bias_wr_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ACC_W-1:0]          in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic                      out_last,
  output logic                      sat_flag,
  output logic                      frame_err
);

  localparam int CW = $clog2(NUM_CH);
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

  logic [BIAS_W-1:0]       rd_bias;
  logic [CW-1:0]           ch_cnt;
  logic                    accept, s1_advance;
  logic                    s1_valid, s1_last;
  logic [CW-1:0]           s1_ch;
  logic signed [ACC_W-1:0] s1_data;
  logic signed [ACC_W:0]   s1_bias, bias_tc;
  logic signed [ACC_W:0]   sum, shr;
  logic signed [63:0]      shr64, sat64;
  logic [OUT_W-1:0]        res;
  logic                    clip;

  bias_regfile #(.NUM_CH(NUM_CH), .BIAS_W(BIAS_W), .AW(CW)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bias_wr_en),
    .wr_addr (bias_wr_addr),
    .wr_data (bias_wr_data),
    .rd_addr (ch_cnt),
    .rd_data (rd_bias)
  );

  assign s1_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;
  assign accept     = in_valid && in_ready;
  assign bias_tc    = (ACC_W+1)'(sm_to_tc(64'(rd_bias), BIAS_W));

  // stage 1: capture beat plus its bias, track channel and framing
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_cnt    <= '0;
      frame_err <= 1'b0;
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_bias   <= '0;
      s1_ch     <= '0;
      s1_last   <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (accept) begin
        s1_data <= $signed(in_data);
        s1_bias <= bias_tc;
        s1_ch   <= ch_cnt;
        s1_last <= in_last;
        ch_cnt  <= (in_last || ch_cnt == LAST_CH) ? '0 : ch_cnt + 1'b1;
        if (in_last != (ch_cnt == LAST_CH)) frame_err <= 1'b1;
      end
    end
  end

  // stage 2 datapath: ACC_W+1 bits hold any acc + bias sum without overflow
  always_comb begin
    sum   = {s1_data[ACC_W-1], s1_data} + s1_bias;
    shr   = sum >>> SHIFT;
    shr64 = 64'(shr);
    sat64 = sat_trunc(shr64, ACC_W + 1, OUT_W);
    clip  = (sat64 != shr64);
    res   = sat64[OUT_W-1:0];
`ifdef BIAS_ADD_RELU_EN
    if (res[OUT_W-1]) res = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
      sat_flag  <= 1'b0;
    end else if (s1_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= res;
        out_ch   <= s1_ch;
        out_last <= s1_last;
        sat_flag <= clip;
      end
    end
  end

endmodule
